// File: rtl/tdc_coarse_capture.sv
// Coarse time-to-digital capture: windowed counter timestamps rising edges of
// the synchronised trigger and queues {phase, ovf, coarse} records in a FWFT FIFO.
module tdc_coarse_capture #(
  parameter int CNT_W    = 10,
  parameter int DEPTH    = 4,
  parameter int MAX_HITS = 4
) (
  input  logic             sync_clk_i,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sync_in,
  input  logic             s_in,
  output logic             busy,
  output logic             done,
  output logic             hit_lost,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_coarse,
  output logic             out_phase,
  output logic             out_ovf
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FCNT_W = $clog2(DEPTH + 1);
  localparam int HIT_W = $clog2(MAX_HITS + 1);
  localparam int REC_W = CNT_W + 2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [HIT_W-1:0]   hits_q, hits_d;
  logic               sync_d_q, sync_d_d;
  logic               hit_lost_q, hit_lost_d;
  logic               done_q, done_d;
  logic [REC_W-1:0]   mem_q [DEPTH];
  logic [REC_W-1:0]   mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FCNT_W-1:0]  fcnt_q, fcnt_d;

  logic               hit_edge, push, push_ok, pop;
  logic [REC_W-1:0]   rec, head;

  // Readout handshake: a record transfers on a cycle where out_valid && out_ready;
  // out_valid never drops and out_* never change while waiting for out_ready.
  assign hit_edge = sync_in & ~sync_d_q;
  assign pop      = (fcnt_q != '0) && out_ready;
  assign push_ok  = push && ((fcnt_q < FCNT_W'(DEPTH)) || pop);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hits_d     = hits_q;
    hit_lost_d = hit_lost_q;
    done_d     = 1'b0;
    sync_d_d   = sync_in;
    push       = 1'b0;
    rec        = '0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_RUN;
          cnt_d      = '0;
          hits_d     = '0;
          hit_lost_d = 1'b0;
        end
      end
      S_RUN: begin
        if (start) begin
          cnt_d      = '0;
          hits_d     = '0;
          hit_lost_d = 1'b0;
        end else begin
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
          if (hit_edge) begin
            push   = 1'b1;
            rec    = {s_in, 1'b0, cnt_q};
            hits_d = hits_q + HIT_W'(1);
            if ((hits_d == HIT_W'(MAX_HITS)) || (cnt_q == CNT_MAX)) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end
          end else if (cnt_q == CNT_MAX) begin
            // Window expired without a hit: leave a timeout marker.
            push    = 1'b1;
            rec     = {s_in, 1'b1, cnt_q};
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (push && !push_ok) hit_lost_d = 1'b1;
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fcnt_d   = fcnt_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = rec;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop})
      2'b10:   fcnt_d = fcnt_q + FCNT_W'(1);
      2'b01:   fcnt_d = fcnt_q - FCNT_W'(1);
      default: fcnt_d = fcnt_q;
    endcase
  end

  always_ff @(posedge sync_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      hits_q     <= '0;
      sync_d_q   <= 1'b0;
      hit_lost_q <= 1'b0;
      done_q     <= 1'b0;
      mem_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hits_q     <= hits_d;
      sync_d_q   <= sync_d_d;
      hit_lost_q <= hit_lost_d;
      done_q     <= done_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fcnt_q     <= fcnt_d;
    end
  end

  // Head fields read as zero when the FIFO is empty.
  assign head       = mem_q[rd_ptr_q];
  assign busy       = (state_q == S_RUN);
  assign done       = done_q;
  assign hit_lost   = hit_lost_q;
  assign out_valid  = (fcnt_q != '0);
  assign out_coarse = out_valid ? head[CNT_W-1:0] : '0;
  assign out_ovf    = out_valid ? head[CNT_W] : 1'b0;
  assign out_phase  = out_valid ? head[CNT_W+1] : 1'b0;

endmodule

// File: tb/tb_tdc_coarse_capture.sv
// Directed bench for tdc_coarse_capture (CNT_W=4, DEPTH=4, MAX_HITS=4):
// a per-cycle vector table plus hand-written timeout, full-FIFO and reset sequences.
module tb_tdc_coarse_capture;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             sync_in = 1'b0;
  logic             s_in = 1'b0;
  logic             out_ready = 1'b0;
  logic             busy, done, hit_lost, out_valid, out_phase, out_ovf;
  logic [CNT_W-1:0] out_coarse;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic             start, sync_in, s_in, out_ready;
    logic             busy, done, valid, phase, ovf;
    logic [CNT_W-1:0] coarse;
  } vec_t;
  vec_t vecs[$];

  // Expected head records packed as {phase, ovf, coarse}.
  logic [CNT_W+1:0] exp_q[$];

  tdc_coarse_capture #(.CNT_W(CNT_W), .DEPTH(4), .MAX_HITS(4)) dut (
    .sync_clk_i(clk), .rst_n(rst_n), .start(start), .sync_in(sync_in), .s_in(s_in),
    .busy(busy), .done(done), .hit_lost(hit_lost), .out_valid(out_valid),
    .out_ready(out_ready), .out_coarse(out_coarse), .out_phase(out_phase), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_head(input string name, input logic [CNT_W+1:0] exp);
    chk({name, ".valid"}, 16'(out_valid), 16'd1);
    chk({name, ".head"}, 16'({out_phase, out_ovf, out_coarse}), 16'(exp));
  endtask

  // Drive inputs on the falling edge, return 1 time unit after the rising edge.
  task automatic step(input logic st, input logic si, input logic ph, input logic rdy);
    @(negedge clk);
    start = st; sync_in = si; s_in = ph; out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  function automatic void add_vec(input logic st, si, ph, rdy, b, d, v, p, o,
                                  input logic [CNT_W-1:0] c);
    vec_t x;
    x.start = st; x.sync_in = si; x.s_in = ph; x.out_ready = rdy;
    x.busy = b; x.done = d; x.valid = v; x.phase = p; x.ovf = o; x.coarse = c;
    vecs.push_back(x);
  endfunction

  initial begin
    // Single hit 5 cycles after start, then restart into four hits 3 cycles apart.
    add_vec(1, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) add_vec(0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    add_vec(0, 1, 1, 0, 1, 0, 1, 1, 0, 4);
    add_vec(0, 0, 1, 1, 1, 0, 0, 0, 0, 0);
    add_vec(1, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    for (int h = 0; h < 4; h++) begin
      add_vec(0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
      add_vec(0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
      if (h < 3) add_vec(0, 1, 0, 1, 1, 0, 1, 0, 0, 4'(3 * h + 2));
      else       add_vec(0, 1, 0, 1, 0, 1, 1, 0, 0, 4'(11));
    end
    add_vec(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst.busy", 16'(busy), 0);
    chk("rst.done", 16'(done), 0);
    chk("rst.hit_lost", 16'(hit_lost), 0);
    chk("rst.valid", 16'(out_valid), 0);
    chk("rst.head", 16'({out_phase, out_ovf, out_coarse}), 0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].start, vecs[i].sync_in, vecs[i].s_in, vecs[i].out_ready);
      chk($sformatf("vec%0d.busy", i), 16'(busy), 16'(vecs[i].busy));
      chk($sformatf("vec%0d.done", i), 16'(done), 16'(vecs[i].done));
      chk($sformatf("vec%0d.valid", i), 16'(out_valid), 16'(vecs[i].valid));
      if (vecs[i].valid)
        chk($sformatf("vec%0d.head", i), 16'({out_phase, out_ovf, out_coarse}),
            16'({vecs[i].phase, vecs[i].ovf, vecs[i].coarse}));
    end

    // Window with no hit runs to terminal count and leaves a timeout record.
    step(1, 0, 1, 0);
    for (int i = 0; i < 15; i++) begin
      step(0, 0, 1, 0);
      chk("tmo.busy", 16'(busy), 1);
      chk("tmo.done_early", 16'(done), 0);
    end
    step(0, 0, 1, 0);
    chk("tmo.busy_end", 16'(busy), 0);
    chk("tmo.done", 16'(done), 1);
    chk_head("tmo.rec", {1'b1, 1'b1, 4'd15});
    step(0, 0, 1, 0);
    chk("tmo.done_pulse", 16'(done), 0);
    step(0, 0, 1, 1);
    chk("tmo.popped", 16'(out_valid), 0);

    // Fill the FIFO with one window, then overflow it from the next.
    step(1, 0, 1, 0);
    for (int h = 0; h < 4; h++) begin
      step(0, 1, 1, 0);
      exp_q.push_back({1'b1, 1'b0, 4'(2 * h)});
      if (h < 3) step(0, 0, 1, 0);
    end
    chk("full.busy", 16'(busy), 0);
    chk("full.done", 16'(done), 1);
    chk_head("full.head0", {1'b1, 1'b0, 4'd0});
    step(0, 0, 1, 0);
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    chk("full.hit_lost", 16'(hit_lost), 1);
    chk_head("full.head_stable", {1'b1, 1'b0, 4'd0});
    step(0, 0, 0, 0);
    chk_head("full.head_stable2", {1'b1, 1'b0, 4'd0});
    // Push into a full FIFO is accepted when a pop happens in the same cycle.
    step(0, 1, 0, 1);
    void'(exp_q.pop_front());
    exp_q.push_back({1'b0, 1'b0, 4'd2});
    chk("full.hit_lost_sticky", 16'(hit_lost), 1);
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) begin
      chk_head($sformatf("drain%0d", i), exp_q.pop_front());
      step(0, 0, 0, 1);
    end
    chk("drain.empty", 16'(out_valid), 0);

    // Hit mid-window, then asynchronous reset between clock edges.
    step(0, 1, 0, 0);
    chk_head("pre_rst.rec", {1'b0, 1'b0, 4'd7});
    #2 rst_n = 1'b0;
    #1;
    chk("arst.busy", 16'(busy), 0);
    chk("arst.valid", 16'(out_valid), 0);
    chk("arst.hit_lost", 16'(hit_lost), 0);
    chk("arst.head", 16'({out_phase, out_ovf, out_coarse}), 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0);
      chk("post_rst.done", 16'(done), 0);
      chk("post_rst.busy", 16'(busy), 0);
    end

    // Trigger already high at start must fall and rise again to count.
    step(0, 1, 1, 0);
    step(0, 1, 1, 0);
    step(1, 1, 1, 0);
    chk("lvl.busy", 16'(busy), 1);
    for (int i = 0; i < 2; i++) begin
      step(0, 1, 1, 0);
      chk("lvl.no_rec", 16'(out_valid), 0);
    end
    step(0, 0, 1, 0);
    chk("lvl.no_rec_low", 16'(out_valid), 0);
    step(0, 1, 1, 0);
    chk_head("lvl.rec", {1'b1, 1'b0, 4'd3});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
